// File: rtl/bch_encode_ctrl_if.sv
// Word-level stream bundle for bch_encode_ctrl: K-bit message in, N-bit codeword out.
interface bch_encode_ctrl_if #(
    parameter int unsigned N = 15,
    parameter int unsigned K = 5
);
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bch_encode_ctrl.sv
// Frame sequencer around a bit-serial BCH encoder: word in, serial shift, codeword collect, word out.
// Optional alignment checker on enc_vdin_i enabled by defining BCH_ENCODE_CTRL_ALIGN_CHECK_EN.
module bch_encode_ctrl #(
    parameter int unsigned N = 15,
    parameter int unsigned K = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bch_encode_ctrl_if.slave bus,
    output logic             enc_reset_o,
    output logic             enc_din_o,
    input  logic             enc_vdin_i,
    input  logic             enc_dout_i,
    output logic             err_o
);
    localparam int unsigned CW = $clog2(N + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state_q,     state_d;
    logic [K-1:0]  msg_q,       msg_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [N-1:0]  cw_q,        cw_d;
    logic [N-1:0]  out_data_q,  out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          cap_en_q,    cap_en_d;
    logic          enc_din_q,   enc_din_d;

    // Next-state, shift and capture logic
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    msg_d   = bus.in_data;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                msg_d = msg_q << 1;
                if (cnt_q == CW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = S_PARITY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == CW'(N - K - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Encoder output is registered, so capture trails the feed phase by one cycle
        cap_en_d    = (state_q == S_DATA) || (state_q == S_PARITY);
        cw_d        = cap_en_q ? {cw_q[N-2:0], enc_dout_i} : cw_q;
        // enc_din is registered: present the bit for the upcoming DATA cycle
        enc_din_d   = (state_d == S_DATA) && msg_d[K-1];
        out_valid_d = (state_d == S_DONE);
        out_data_d  = (state_q == S_DRAIN) ? cw_d : out_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            msg_q       <= '0;
            cnt_q       <= '0;
            cw_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cap_en_q    <= 1'b0;
            enc_din_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            cnt_q       <= cnt_d;
            cw_q        <= cw_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cap_en_q    <= cap_en_d;
            enc_din_q   <= enc_din_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !reset_i;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign enc_reset_o   = reset_i || (state_q == S_START);
    assign enc_din_o     = enc_din_q;

`ifdef BCH_ENCODE_CTRL_ALIGN_CHECK_EN
    logic err_q, err_d;

    // Sticky flag when the encoder's data phase disagrees with ours
    always_comb begin
        err_d = err_q;
        if ((state_q == S_DATA) && !enc_vdin_i) begin
            err_d = 1'b1;
        end
        if (((state_q == S_PARITY) || (state_q == S_START)) && enc_vdin_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_enc_vdin;
    assign unused_enc_vdin = enc_vdin_i;
    assign err_o           = 1'b0;
`endif

endmodule

// File: tb/tb_bch_encode_ctrl.sv
// Scoreboard bench for bch_encode_ctrl driving a behavioural serial BCH(15,5) encoder.
module tb_bch_encode_ctrl;
    localparam int unsigned N = 15;
    localparam int unsigned K = 5;
    localparam logic [10:0] GEN  = 11'h537;  // x^10+x^8+x^5+x^4+x^2+x+1
    localparam logic [9:0]  GLOW = 10'h137;
`ifdef BCH_ENCODE_CTRL_ALIGN_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic enc_reset, enc_din, enc_vdin, enc_dout, err;

    bch_encode_ctrl_if #(.N(N), .K(K)) bus ();

    bch_encode_ctrl #(.N(N), .K(K)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .bus         (bus),
        .enc_reset_o (enc_reset),
        .enc_din_o   (enc_din),
        .enc_vdin_i  (enc_vdin),
        .enc_dout_i  (enc_dout),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Systematic codeword by polynomial long division: parity = m(x)*x^(N-K) mod g(x)
    function automatic logic [N-1:0] ref_codeword(input logic [K-1:0] m);
        logic [N-1:0] r;
        r = {m, {(N-K){1'b0}}};
        for (int i = N - 1; i >= int'(N - K); i--) begin
            if (r[i]) r = r ^ (N'(GEN) << (i - int'(N - K)));
        end
        return {m, r[N-K-1:0]};
    endfunction

    // Behavioural serial encoder: K pass-through bits then N-K parity bits, registered output
    logic [N-K-1:0] lfsr       = '0;
    int             ecnt       = 100;
    logic           enc_dout_r = 1'b0;
    logic           vdin_kill  = 1'b0;
    always @(posedge clk) begin
        if (enc_reset) begin
            lfsr       <= '0;
            ecnt       <= 0;
            enc_dout_r <= 1'b0;
        end else begin
            if (ecnt < int'(K)) begin
                enc_dout_r <= enc_din;
                lfsr       <= (lfsr << 1) ^ ((enc_din ^ lfsr[N-K-1]) ? GLOW : 10'd0);
            end else begin
                enc_dout_r <= lfsr[N-K-1];
                lfsr       <= lfsr << 1;
            end
            if (ecnt < 100) ecnt <= ecnt + 1;
        end
    end
    assign enc_dout = enc_dout_r;
    assign enc_vdin = (ecnt < int'(K)) && !vdin_kill;

    // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
    int rdy_mode = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard state shared between stimulus and monitor
    logic [N-1:0] exp_q[$];
    int           acc_q[$];
    logic [K-1:0] dmsg_q[$];
    int           last_acc = -1;
    int           prev_acc = -1;
    logic [N-1:0] last_out = '0;
    logic [N-1:0] held     = '0;
    logic         ov_prev  = 1'b0;
    logic         idle_chk = 1'b0;
    logic [K-1:0] cur      = '0;
    int           ph       = -1;
    int           er_len   = 0;

    // Monitor: pops expectations whenever the DUT presents something
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
            dmsg_q.delete();
            ph       = -1;
            idle_chk = 1'b0;
            ov_prev  = 1'b0;
            er_len   = 0;
        end else begin
            if (idle_chk) begin
                check("idle_after_out_hs", 32'(bus.in_ready), 32'd1);
                check("out_data_kept", 32'(bus.out_data), 32'(last_out));
                idle_chk = 1'b0;
            end
            if (ph >= 0) begin
                check("enc_din_seq", 32'(enc_din), 32'((ph < int'(K)) ? cur[K-1-ph] : 1'b0));
                ph++;
                if (ph == int'(N)) ph = -1;
            end
            if (enc_reset) begin
                er_len++;
                check("enc_din_start", 32'(enc_din), 32'd0);
                if (dmsg_q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL enc_reset_unexpected: pulse with no accepted message (cycle %0d)", cyc);
                end else begin
                    cur = dmsg_q.pop_front();
                end
                ph = 0;
            end else if (er_len > 0) begin
                check("enc_reset_width", 32'(er_len), 32'd1);
                er_len = 0;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_codeword(bus.in_data));
                acc_q.push_back(cyc);
                dmsg_q.push_back(bus.in_data);
                prev_acc = last_acc;
                last_acc = cyc;
            end
            if (bus.out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL latency: out_valid with no accepted message (cycle %0d)", cyc);
                end else begin
                    check("latency", 32'(cyc - acc_q.pop_front()), 32'(N + 3));
                end
            end
            if (bus.out_valid && ov_prev) begin
                check("hold_out_data", 32'(bus.out_data), 32'(held));
                check("busy_in_ready", 32'(bus.in_ready), 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL codeword: got 0x%0h expected none (cycle %0d)", bus.out_data, cyc);
                end else begin
                    check("codeword", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
                last_out = bus.out_data;
                idle_chk = 1'b1;
            end
            ov_prev = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
        end
    end

    task automatic send(input logic [K-1:0] m);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = m;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready && !reset) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_data  = K'($urandom);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.in_ready) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int nv;
        bit seen;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_enc_reset", 32'(enc_reset), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_enc_din", 32'(enc_din), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) begin @(posedge clk); #1; end

        send(5'b00000);
        wait_idle();
        check("zero_codeword", 32'(last_out), 32'h0000);

        send(5'b10110);
        wait_idle();
        check("golden_10110", 32'(last_out), 32'h591E);

        // Backpressure: stall the consumer 20 cycles after out_valid
        rdy_mode = 2;
        send(K'($urandom));
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("bp_out_valid_seen", 32'(seen), 32'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bp_still_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        rdy_mode = 0;
        wait_idle();

        // Back-to-back with in_valid held
        send(5'b11111);
        send(5'b00001);
        wait_idle();
        check("b2b_period", 32'(last_acc - prev_acc), 32'(N + 4));

        // Reset during the third DATA cycle
        send(5'b10110);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 32'(bus.in_ready), 32'd1);
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.out_valid) nv++;
        end
        check("no_out_after_abort", 32'(nv), 32'd0);
        @(posedge clk); #1;
        send(5'b10110);
        wait_idle();
        check("golden_after_abort", 32'(last_out), 32'h591E);

        // Randomised frames with random consumer stalls and idle gaps
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            send(K'($urandom));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_idle();
        rdy_mode = 0;
        repeat (2) begin @(posedge clk); #1; end

        // Alignment check: drop enc_vdin for one DATA cycle
        check("err_clear", 32'(err), 32'd0);
        send(K'($urandom));
        @(posedge clk); #1;
        vdin_kill = 1'b1;
        @(negedge clk);
        check("err_before", 32'(err), 32'd0);
        @(posedge clk); #1;
        vdin_kill = 1'b0;
        @(negedge clk);
        check("err_rise", 32'(err), 32'(EXP_ERR));
        wait_idle();
        check("err_sticky", 32'(err), 32'(EXP_ERR));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("err_after_reset", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bch_encode_ctrl.md
Name:
bch_encode_ctrl

Overview:
- Frame sequencer that wraps the serial BCH encoder datapath for word-level use.
- Accepts a K-bit message over a valid/ready handshake and pulses the encoder's reset to align a fresh frame.
- Shifts the message MSB-first into the encoder, then collects the N serial code bits and presents the full codeword over a valid/ready handshake.
- Sits between a parallel producer and the bit-serial encoder instance.

Parameters:
- N, 15: codeword length in bits.
- K, 5: message length in bits; requires 1 <= K < N.
- CW, $clog2(N+1): width of the internal bit counter (localparam, not overridable).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  message available.
- in_ready  out  1  controller can accept a message.
- in_data  in  K  message word; in_data[K-1] is sent first.
- out_valid  out  1  codeword available.
- out_ready  in  1  consumer accepts the codeword.
- out_data  out  N  codeword; out_data[N-1] is the first bit emitted.
- enc_reset  out  1  drives the encoder's reset.
- enc_din  out  1  drives the encoder's serial input.
- enc_vdin  in  1  encoder's data-phase indicator.
- enc_dout  in  1  encoder's registered serial output.
- err  out  1  sticky alignment error (optional feature only; tied 0 otherwise).

Behaviour:
- States: IDLE, START, DATA, PARITY, DRAIN, DONE.
- IDLE:
  - in_ready = 1 (combinational: state==IDLE && !reset).
  - On in_valid && in_ready: latch in_data into shift register msg, clear cnt, go to START.
- START (1 cycle):
  - enc_reset = 1, enc_din = 0.
  - Next state is DATA, cnt = 0.
- DATA (K cycles):
  - enc_din = msg[K-1]; msg shifts left each cycle.
  - cnt increments; when cnt == K-1, go to PARITY with cnt = 0.
- PARITY (N-K cycles):
  - enc_din = 0.
  - When cnt == N-K-1, go to DRAIN.
- DRAIN (1 cycle):
  - Captures the final encoder bit, then goes to DONE.
- Capture:
  - cap_en is a register set in cycles where state is DATA or PARITY, so it is delayed one cycle.
  - When cap_en = 1, shift cw = {cw[N-2:0], enc_dout}.
  - This gives exactly N captures, matching the encoder's one-cycle registered output.
- DONE:
  - out_valid = 1 and out_data = cw, held stable until out_ready.
  - On out_valid && out_ready, go to IDLE next cycle.
  - out_data keeps its last value after the handshake.
- enc_reset is the OR of reset and (state == START).
- Latency:
  - Input handshake at cycle 0; out_valid first high at cycle N+3 (18 for the defaults).
  - Minimum period between accepted messages is N+4 cycles when out_ready is tied 1.
- No overlap: in_ready stays 0 from acceptance until the output handshake completes.
- Reset values:
  - state = IDLE, out_valid = 0, out_data = 0, cw = 0, msg = 0, cnt = 0, cap_en = 0, enc_din = 0, err = 0.
  - in_ready = 0 while reset is high; enc_reset = 1 while reset is high.
- Reset mid-frame: abort immediately, discard partial cw, return to IDLE next cycle; no codeword is emitted.
- in_valid while busy: ignored; the producer holds it.
- in_data changes after acceptance have no effect.
- out_ready while not DONE: ignored.

Optional Feature:
- Macro: BCH_ENCODE_CTRL_ALIGN_CHECK_EN.
- Defined:
  - err is set when enc_vdin != 1 in any DATA cycle, or when enc_vdin != 0 in any PARITY cycle or in the START cycle.
  - err is sticky and cleared only by reset.
  - The frame still completes normally.
- Undefined:
  - No check logic is compiled in.
  - err is tied to 0 and enc_vdin is unused.

Test Plan:
- Basic frame, defaults, in_data = 5'b00000, out_ready = 1:
  - out_valid rises 18 cycles after the handshake.
  - out_data = 15'h0000.
  - enc_reset pulses exactly one cycle.
- in_data = 5'b10110:
  - enc_din shows 1,0,1,1,0 over the five DATA cycles, then ten 0s.
  - out_data[14:10] = 5'b10110 (systematic).
  - out_data[9:0] matches the golden BCH(15,5) parity from the software model.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid: out_data stays stable and in_ready stays 0.
  - Raise out_ready: IDLE follows on the next cycle.
- Back-to-back messages 5'b11111 then 5'b00001 with in_valid held high:
  - Second acceptance occurs exactly N+4 = 19 cycles after the first.
  - Both codewords match the model.
- Reset asserted for one cycle at the 3rd DATA cycle:
  - No out_valid is produced.
  - in_ready = 1 on the cycle after reset deasserts.
  - The next frame with 5'b10110 is correct.
- With BCH_ENCODE_CTRL_ALIGN_CHECK_EN, enc_vdin forced to 0 in one DATA cycle:
  - err rises the next cycle and stays 1 until reset.
  - Without the macro, err stays 0.
